// File: rtl/cache_ctrl_pkg.sv
// Shared types, address geometry and helpers for the cache command sequencer.
package cache_ctrl_pkg;

  localparam int ADDR_W      = 32;
  localparam int OFFSET_BITS = 6;
  localparam int INDEX_BITS  = 4;
  localparam int TAG_BITS    = ADDR_W - INDEX_BITS - OFFSET_BITS;
  localparam int SETS        = 1 << INDEX_BITS;

  typedef enum logic [3:0] {
    CMD_READ   = 4'd0,
    CMD_WRITE  = 4'd1,
    CMD_IFETCH = 4'd2,
    CMD_INVAL  = 4'd3,
    CMD_CLEAR  = 4'd8,
    CMD_PRINT  = 4'd9
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    LK   = 3'd2,
    WB   = 3'd3,
    FIL  = 3'd4,
    UPD  = 3'd5,
    CLR  = 3'd6
  } ctrl_state_e;

  typedef enum logic {
    BUS_READ      = 1'b0,
    BUS_WRITEBACK = 1'b1
  } bus_op_e;

  typedef struct packed {
    logic [TAG_BITS-1:0]    tag;
    logic [INDEX_BITS-1:0]  index;
    logic [OFFSET_BITS-1:0] offset;
  } addr_t;

  function automatic addr_t address_parse(input logic [ADDR_W-1:0] addr);
    return addr_t'(addr);
  endfunction

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_BITS-1:0] tag,
                                                  input logic [INDEX_BITS-1:0] index);
    return {tag, index, {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that sticks at all-ones and clears synchronously.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // next count: clear wins, increment only below the saturation point
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cache_ctrl.sv
// Trace command sequencer: tag lookup, victim writeback, line fill, tag/LRU update,
// full-array clear and hit/miss statistics. All outputs are registered.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter  int WAYS     = 8,
  parameter  int CNT_W    = 32,
  localparam int WAY_BITS = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_code,
  input  logic [ADDR_W-1:0]     cmd_addr,
  output logic                  ta_rd_en,
  output logic [INDEX_BITS-1:0] ta_index,
  input  logic                  ta_hit,
  input  logic [WAY_BITS-1:0]   ta_hit_way,
  input  logic [WAY_BITS-1:0]   ta_victim_way,
  input  logic                  ta_victim_valid,
  input  logic                  ta_victim_dirty,
  input  logic [TAG_BITS-1:0]   ta_victim_tag,
  output logic                  ta_wr_en,
  output logic [WAY_BITS-1:0]   ta_wr_way,
  output logic [TAG_BITS-1:0]   ta_wr_tag,
  output logic [1:0]            ta_wr_state,
  output logic                  ta_touch,
  output logic                  bus_req,
  output logic                  bus_op,
  output logic [ADDR_W-1:0]     bus_addr,
  input  logic                  bus_ack,
  output logic                  cache_read,
  output logic                  cache_write,
  output logic                  cache_hit,
  output logic                  cache_miss,
  output logic                  print_req,
  output logic                  cmd_err,
  output logic [CNT_W-1:0]      rd_cnt,
  output logic [CNT_W-1:0]      wr_cnt,
  output logic [CNT_W-1:0]      hit_cnt,
  output logic [CNT_W-1:0]      miss_cnt
);

  localparam int CLR_W = INDEX_BITS + WAY_BITS;
  localparam logic [CLR_W-1:0] CLR_ONE = CLR_W'(1);

  ctrl_state_e           state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  ta_rd_en_q, ta_rd_en_d;
  logic [INDEX_BITS-1:0] ta_index_q, ta_index_d;
  logic                  ta_wr_en_q, ta_wr_en_d;
  logic [WAY_BITS-1:0]   ta_wr_way_q, ta_wr_way_d;
  logic [TAG_BITS-1:0]   ta_wr_tag_q, ta_wr_tag_d;
  logic [1:0]            ta_wr_state_q, ta_wr_state_d;
  logic                  ta_touch_q, ta_touch_d;
  logic                  bus_req_q, bus_req_d;
  bus_op_e               bus_op_q, bus_op_d;
  logic [ADDR_W-1:0]     bus_addr_q, bus_addr_d;
  logic                  cache_read_q, cache_read_d;
  logic                  cache_write_q, cache_write_d;
  logic                  cache_hit_q, cache_hit_d;
  logic                  cache_miss_q, cache_miss_d;
  logic                  print_req_q, print_req_d;
  logic                  cmd_err_q, cmd_err_d;
  logic [TAG_BITS-1:0]   tag_q, tag_d;
  logic [INDEX_BITS-1:0] index_q, index_d;
  logic                  is_write_q, is_write_d;
  logic                  is_inval_q, is_inval_d;
  logic [WAY_BITS-1:0]   hit_way_q, hit_way_d;
  logic [WAY_BITS-1:0]   victim_way_q, victim_way_d;
  logic [CLR_W-1:0]      clr_idx_q, clr_idx_d;

  addr_t            cmd_fields_s;
  logic             unused_offset_s;
  logic [CLR_W-1:0] clr_next_s;
  logic             inc_rd_s, inc_wr_s, inc_hit_s, inc_miss_s, clr_cnt_s;

  assign cmd_fields_s    = address_parse(cmd_addr);
  assign unused_offset_s = ^cmd_fields_s.offset;
  assign clr_next_s      = clr_idx_q + CLR_ONE;

  // next-state, registered-output and statistics-strobe decode
  always_comb begin
    state_d       = state_q;
    ta_rd_en_d    = 1'b0;
    ta_index_d    = ta_index_q;
    ta_wr_en_d    = 1'b0;
    ta_wr_way_d   = ta_wr_way_q;
    ta_wr_tag_d   = ta_wr_tag_q;
    ta_wr_state_d = ta_wr_state_q;
    ta_touch_d    = 1'b0;
    bus_req_d     = 1'b0;
    bus_op_d      = bus_op_q;
    bus_addr_d    = bus_addr_q;
    cache_read_d  = 1'b0;
    cache_write_d = 1'b0;
    cache_hit_d   = 1'b0;
    cache_miss_d  = 1'b0;
    print_req_d   = 1'b0;
    cmd_err_d     = 1'b0;
    tag_d         = tag_q;
    index_d       = index_q;
    is_write_d    = is_write_q;
    is_inval_d    = is_inval_q;
    hit_way_d     = hit_way_q;
    victim_way_d  = victim_way_q;
    clr_idx_d     = clr_idx_q;
    inc_rd_s      = 1'b0;
    inc_wr_s      = 1'b0;
    inc_hit_s     = 1'b0;
    inc_miss_s    = 1'b0;
    clr_cnt_s     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          case (cmd_code)
            CMD_READ, CMD_IFETCH, CMD_WRITE, CMD_INVAL: begin
              tag_d      = cmd_fields_s.tag;
              index_d    = cmd_fields_s.index;
              is_write_d = (cmd_code == CMD_WRITE);
              is_inval_d = (cmd_code == CMD_INVAL);
              ta_rd_en_d = 1'b1;
              ta_index_d = cmd_fields_s.index;
              state_d    = RD;
            end
            CMD_CLEAR: begin
              clr_idx_d     = '0;
              ta_wr_en_d    = 1'b1;
              ta_index_d    = '0;
              ta_wr_way_d   = '0;
              ta_wr_tag_d   = '0;
              ta_wr_state_d = 2'b00;
              state_d       = CLR;
            end
            CMD_PRINT: print_req_d = 1'b1;
            default:   cmd_err_d   = 1'b1;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      RD: state_d = LK;
      LK: begin
        hit_way_d    = ta_hit_way;
        victim_way_d = ta_victim_way;
        if (is_inval_q) begin
          // on a hit the array reports the hitting line's state on the victim_* lines
          if (ta_hit && ta_victim_dirty) begin
            bus_req_d  = 1'b1;
            bus_op_d   = BUS_WRITEBACK;
            bus_addr_d = line_addr(tag_q, index_q);
            state_d    = WB;
          end else if (ta_hit) begin
            ta_wr_en_d    = 1'b1;
            ta_index_d    = index_q;
            ta_wr_way_d   = ta_hit_way;
            ta_wr_tag_d   = tag_q;
            ta_wr_state_d = 2'b00;
            state_d       = UPD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cache_read_d  = !is_write_q;
          cache_write_d = is_write_q;
          inc_rd_s      = !is_write_q;
          inc_wr_s      = is_write_q;
          if (ta_hit && is_write_q) begin
            cache_hit_d   = 1'b1;
            inc_hit_s     = 1'b1;
            ta_wr_en_d    = 1'b1;
            ta_touch_d    = 1'b1;
            ta_index_d    = index_q;
            ta_wr_way_d   = ta_hit_way;
            ta_wr_tag_d   = tag_q;
            ta_wr_state_d = 2'b11;
            state_d       = UPD;
          end else if (ta_hit) begin
            cache_hit_d = 1'b1;
            inc_hit_s   = 1'b1;
            ta_touch_d  = 1'b1;
            ta_wr_way_d = ta_hit_way;
            state_d     = IDLE;
          end else begin
            cache_miss_d = 1'b1;
            inc_miss_s   = 1'b1;
            bus_req_d    = 1'b1;
            if (ta_victim_valid && ta_victim_dirty) begin
              bus_op_d   = BUS_WRITEBACK;
              bus_addr_d = line_addr(ta_victim_tag, index_q);
              state_d    = WB;
            end else begin
              bus_op_d   = BUS_READ;
              bus_addr_d = line_addr(tag_q, index_q);
              state_d    = FIL;
            end
          end
        end
      end
      WB: begin
        if (bus_ack && is_inval_q) begin
          ta_wr_en_d    = 1'b1;
          ta_index_d    = index_q;
          ta_wr_way_d   = hit_way_q;
          ta_wr_tag_d   = tag_q;
          ta_wr_state_d = 2'b00;
          state_d       = UPD;
        end else if (bus_ack) begin
          bus_req_d  = 1'b1;
          bus_op_d   = BUS_READ;
          bus_addr_d = line_addr(tag_q, index_q);
          state_d    = FIL;
        end else begin
          bus_req_d = 1'b1;
        end
      end
      FIL: begin
        if (bus_ack) begin
          ta_wr_en_d    = 1'b1;
          ta_touch_d    = 1'b1;
          ta_index_d    = index_q;
          ta_wr_way_d   = victim_way_q;
          ta_wr_tag_d   = tag_q;
          ta_wr_state_d = {1'b1, is_write_q};
          state_d       = UPD;
        end else begin
          bus_req_d = 1'b1;
        end
      end
      UPD: state_d = IDLE;
      CLR: begin
        // clr_idx is {set, way}: ways sweep fastest
        if (clr_idx_q == '1) begin
          clr_cnt_s = 1'b1;
          state_d   = IDLE;
        end else begin
          clr_idx_d     = clr_next_s;
          ta_wr_en_d    = 1'b1;
          ta_index_d    = clr_next_s[CLR_W-1 -: INDEX_BITS];
          ta_wr_way_d   = clr_next_s[WAY_BITS-1:0];
          ta_wr_tag_d   = '0;
          ta_wr_state_d = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  // state, context and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      ta_rd_en_q    <= 1'b0;
      ta_index_q    <= '0;
      ta_wr_en_q    <= 1'b0;
      ta_wr_way_q   <= '0;
      ta_wr_tag_q   <= '0;
      ta_wr_state_q <= 2'b00;
      ta_touch_q    <= 1'b0;
      bus_req_q     <= 1'b0;
      bus_op_q      <= BUS_READ;
      bus_addr_q    <= '0;
      cache_read_q  <= 1'b0;
      cache_write_q <= 1'b0;
      cache_hit_q   <= 1'b0;
      cache_miss_q  <= 1'b0;
      print_req_q   <= 1'b0;
      cmd_err_q     <= 1'b0;
      tag_q         <= '0;
      index_q       <= '0;
      is_write_q    <= 1'b0;
      is_inval_q    <= 1'b0;
      hit_way_q     <= '0;
      victim_way_q  <= '0;
      clr_idx_q     <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      ta_rd_en_q    <= ta_rd_en_d;
      ta_index_q    <= ta_index_d;
      ta_wr_en_q    <= ta_wr_en_d;
      ta_wr_way_q   <= ta_wr_way_d;
      ta_wr_tag_q   <= ta_wr_tag_d;
      ta_wr_state_q <= ta_wr_state_d;
      ta_touch_q    <= ta_touch_d;
      bus_req_q     <= bus_req_d;
      bus_op_q      <= bus_op_d;
      bus_addr_q    <= bus_addr_d;
      cache_read_q  <= cache_read_d;
      cache_write_q <= cache_write_d;
      cache_hit_q   <= cache_hit_d;
      cache_miss_q  <= cache_miss_d;
      print_req_q   <= print_req_d;
      cmd_err_q     <= cmd_err_d;
      tag_q         <= tag_d;
      index_q       <= index_d;
      is_write_q    <= is_write_d;
      is_inval_q    <= is_inval_d;
      hit_way_q     <= hit_way_d;
      victim_way_q  <= victim_way_d;
      clr_idx_q     <= clr_idx_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_rd_cnt   (.clk(clk), .rst_n(rst_n), .inc(inc_rd_s),   .clr(clr_cnt_s), .cnt(rd_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_wr_cnt   (.clk(clk), .rst_n(rst_n), .inc(inc_wr_s),   .clr(clr_cnt_s), .cnt(wr_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt  (.clk(clk), .rst_n(rst_n), .inc(inc_hit_s),  .clr(clr_cnt_s), .cnt(hit_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (.clk(clk), .rst_n(rst_n), .inc(inc_miss_s), .clr(clr_cnt_s), .cnt(miss_cnt));

  assign cmd_ready   = cmd_ready_q;
  assign ta_rd_en    = ta_rd_en_q;
  assign ta_index    = ta_index_q;
  assign ta_wr_en    = ta_wr_en_q;
  assign ta_wr_way   = ta_wr_way_q;
  assign ta_wr_tag   = ta_wr_tag_q;
  assign ta_wr_state = ta_wr_state_q;
  assign ta_touch    = ta_touch_q;
  assign bus_req     = bus_req_q;
  assign bus_op      = bus_op_q;
  assign bus_addr    = bus_addr_q;
  assign cache_read  = cache_read_q;
  assign cache_write = cache_write_q;
  assign cache_hit   = cache_hit_q;
  assign cache_miss  = cache_miss_q;
  assign print_req   = print_req_q;
  assign cmd_err     = cmd_err_q;

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Command sequencer for the cache simulator. Accepts one trace command (code + 32-bit address) per handshake from the trace-reading front end.
- Performs the tag lookup and sequences victim writeback and line fill on a simple bus. Updates tag/state and LRU, and keeps hit/miss statistics.
- Sits between the trace/file front end and the tag array, and owns all sequencing of the tag array and the bus.

Parameters:
WAYS, 8, associativity (power of 2); WAY_BITS = $clog2(WAYS)
CNT_W, 32, width of each statistics counter

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_code  in  4  trace command code
cmd_addr  in  32  trace address
ta_rd_en  out  1  tag array read strobe
ta_index  out  INDEX_BITS  set index for read/write
ta_hit  in  1  lookup hit, valid the cycle after ta_rd_en
ta_hit_way  in  WAY_BITS  hitting way
ta_victim_way  in  WAY_BITS  LRU victim way
ta_victim_valid  in  1  victim line valid
ta_victim_dirty  in  1  victim line dirty
ta_victim_tag  in  TAG_BITS  victim tag
ta_wr_en  out  1  tag/state write strobe
ta_wr_way  out  WAY_BITS  way written
ta_wr_tag  out  TAG_BITS  tag written
ta_wr_state  out  2  {valid,dirty}
ta_touch  out  1  LRU update for ta_wr_way/ta_hit_way
bus_req  out  1  bus request, held until ack
bus_op  out  1  0=READ (fill), 1=WRITEBACK
bus_addr  out  32  line-aligned address (offset bits zero)
bus_ack  in  1  one-cycle completion
cache_read, cache_write, cache_hit, cache_miss  out  1 each  one-cycle event pulses
print_req  out  1  one-cycle pulse, code 9
cmd_err  out  1  one-cycle pulse, unsupported code
rd_cnt, wr_cnt, hit_cnt, miss_cnt  out  CNT_W each  statistics

Behaviour:
- Reset: all outputs 0; counters 0; state IDLE. Reset has priority at any state: bus_req drops at that edge, and the in-flight command is discarded.
- Command codes:
  - 0 = data read
  - 2 = instruction fetch (treated as a read)
  - 1 = write
  - 3 = invalidate
  - 8 = clear
  - 9 = print
  - any other code: cmd_err pulse, no other effect.
- Handshake: cmd_ready=1 only in IDLE. Transfer occurs when cmd_valid && cmd_ready. Code and address are registered and split into tag/index/offset using the mypkg widths.
- IDLE: on accepting code 9, pulse print_req and stay in IDLE. Code 8 goes to CLR. Codes 0/1/2/3 go to RD.
- RD: ta_rd_en=1 with ta_index = captured index; next state LK.
- LK: samples the ta_* lookup results.
  - Read or write: pulse cache_read or cache_write, and increment rd_cnt or wr_cnt.
  - Read hit: pulse cache_hit, hit_cnt++, ta_touch on ta_hit_way, go to IDLE. Hit latency is 3 cycles from accept to cmd_ready.
  - Write hit: pulse cache_hit, hit_cnt++, go to UPD writing {1,1} to ta_hit_way.
  - Read or write miss: pulse cache_miss, miss_cnt++. If the victim is valid and dirty, go to WB; otherwise go to FIL.
  - Invalidate hit: if the line is dirty go to WB, otherwise go to UPD writing {0,0}.
  - Invalidate miss: go to IDLE. No counters change.
- WB: bus_req=1, bus_op=1.
  - bus_addr = {ta_victim_tag, index, 0} for a miss; the hit line's address for an invalidate.
  - On bus_ack, go to FIL (miss) or UPD (invalidate).
- FIL: bus_req=1, bus_op=0, bus_addr = {tag, index, 0}. On bus_ack go to UPD.
- UPD: one cycle. ta_wr_en=1 and ta_touch=1 (except for invalidate).
  - Fill writes tag with state {1, is_write} into ta_victim_way.
  - Then go to IDLE.
- Lookup results are latched in LK; the tag array is not required to hold them.
- CLR: sweeps set 0..2^INDEX_BITS-1 and, within each set, way 0..WAYS-1, one write per cycle with state {0,0}.
  - After the last write, all counters are zeroed and the state returns to IDLE.
  - No bus traffic. Takes exactly SETS*WAYS cycles.
- bus_ack outside WB/FIL is ignored. bus_req never deasserts before ack.
- Counters saturate at all-ones and do not wrap.
- Event pulses never coincide with ta_wr_en from the same command, except on a write hit.

Decomposition:
- mypkg gains:
  - cmd_e enum with the codes above
  - ctrl_state_e {IDLE, RD, LK, WB, FIL, UPD, CLR}
  - bus_op_e
  - TAG_BITS/INDEX_BITS/OFFSET_BITS, which are reused.
- Address splitting reuses the existing address_parse instance.
- One sub-module: sat_counter (CNT_W, inc, clr), instantiated 4 times.

Test Plan:
- Reset while in FIL with bus_req=1, rst_n=0 for 1 cycle: bus_req=0 and cmd_ready=1 on the next cycle, counters 0.
- Read 0x0000_1234, lookup returns ta_hit=1 way 3: cache_read and cache_hit pulse; rd_cnt=1, hit_cnt=1; ta_touch way 3; cmd_ready returns 3 cycles after accept; no bus_req.
- Write 0x0ABC_0040, miss, victim valid+dirty tag 0x0FF:
  - WB with bus_addr={0x0FF, index, 0} until ack;
  - then FIL with bus_addr=0x0ABC_0040 aligned;
  - then UPD with ta_wr_state=2'b11 on the victim way;
  - miss_cnt=1, wr_cnt=1.
- Invalidate, hit on a clean line: UPD writes {0,0} with no bus_req and no counter change. Invalidate miss: returns to IDLE after LK.
- Code 8 after 5 commands: exactly SETS*WAYS consecutive ta_wr_en cycles with state 0, then all counters read 0. Code 9: print_req pulses once and cmd_ready stays 1. Code 5: cmd_err pulses.
- Force hit_cnt to all-ones, then another read hit: hit_cnt remains 32'hFFFF_FFFF.
